// File: rtl/multi_edge_debouncer.sv
// N-channel button/switch conditioner: per-channel synchroniser, counter debouncer,
// registered edge pulses and an optional hold-to-repeat pulse train.
module multi_edge_debouncer #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_START    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] level_in,
  input  logic [CHANNELS-1:0] repeat_en,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] p_edge,
  output logic [CHANNELS-1:0] n_edge,
  output logic [CHANNELS-1:0] rpt_pulse,
  output logic                any_edge
);

  localparam int DCNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX   = (REPEAT_START > REPEAT_PERIOD) ? REPEAT_START : REPEAT_PERIOD;
  localparam int RCNT_W = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DCNT_W-1:0] DC_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0] RS_LAST = RCNT_W'(REPEAT_START - 1);
  localparam logic [RCNT_W-1:0] RP_LAST = RCNT_W'(REPEAT_PERIOD - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RPT  = 2'd2;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [DCNT_W-1:0]      r_dcnt;
    logic                   r_level;
    logic                   r_pedge;
    logic                   r_nedge;
    logic [1:0]             r_state;
    logic [RCNT_W-1:0]      r_rcnt;
    logic                   r_rpt;
    logic                   w_sync;
    logic                   w_accept;
    logic                   w_active;

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_accept = (w_sync != r_level) && (r_dcnt == DC_LAST);
    assign w_active = r_level & repeat_en[c];

    // Stage: synchroniser chain
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_sync <= '0;
      else     r_sync <= {r_sync[SYNC_STAGES-2:0], level_in[c]};
    end

    // Stage: debounce counter and edge pulses, which share the acceptance edge
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_dcnt  <= '0;
        r_level <= 1'b0;
        r_pedge <= 1'b0;
        r_nedge <= 1'b0;
      end else begin
        r_pedge <= w_accept & w_sync;
        r_nedge <= w_accept & ~w_sync;
        if (w_sync == r_level) begin
          r_dcnt <= '0;
        end else if (w_accept) begin
          r_level <= w_sync;
          r_dcnt  <= '0;
        end else begin
          r_dcnt <= r_dcnt + 1'b1;
        end
      end
    end

    // Stage: auto-repeat; IDLE counts as the first held cycle, hence rcnt starts at 1
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= ST_IDLE;
        r_rcnt  <= '0;
        r_rpt   <= 1'b0;
      end else begin
        r_rpt <= 1'b0;
        if (!w_active) begin
          r_state <= ST_IDLE;
          r_rcnt  <= '0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (REPEAT_START == 1) begin
                r_rpt   <= 1'b1;
                r_rcnt  <= '0;
                r_state <= ST_RPT;
              end else begin
                r_rcnt  <= RCNT_W'(1);
                r_state <= ST_WAIT;
              end
            end
            ST_WAIT: begin
              if (r_rcnt == RS_LAST) begin
                r_rpt   <= 1'b1;
                r_rcnt  <= '0;
                r_state <= ST_RPT;
              end else begin
                r_rcnt <= r_rcnt + 1'b1;
              end
            end
            ST_RPT: begin
              if (r_rcnt == RP_LAST) begin
                r_rpt  <= 1'b1;
                r_rcnt <= '0;
              end else begin
                r_rcnt <= r_rcnt + 1'b1;
              end
            end
            default: begin
              r_state <= ST_IDLE;
              r_rcnt  <= '0;
            end
          endcase
        end
      end
    end

    assign level_out[c] = r_level;
    assign p_edge[c]    = r_pedge;
    assign n_edge[c]    = r_nedge;
    assign rpt_pulse[c] = r_rpt;
  end

  assign any_edge = |(p_edge | n_edge);

endmodule

// File: tb/tb_multi_edge_debouncer.sv
// Scoreboard bench: a windowed reference model predicts every cycle's outputs,
// a monitor process pops and compares them after each clock edge.
module tb_multi_edge_debouncer;
  localparam int CH = 4;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int RS = 8;
  localparam int RP = 4;
  localparam int HL = SS + DB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] level_in = '0;
  logic [CH-1:0] repeat_en = '0;
  logic [CH-1:0] level_out, p_edge, n_edge, rpt_pulse;
  logic          any_edge;

  multi_edge_debouncer #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
    .REPEAT_START(RS), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .level_in(level_in), .repeat_en(repeat_en),
    .level_out(level_out), .p_edge(p_edge), .n_edge(n_edge),
    .rpt_pulse(rpt_pulse), .any_edge(any_edge)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] lvl;
    logic [CH-1:0] p;
    logic [CH-1:0] n;
    logic [CH-1:0] r;
    logic          any;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int pc[CH], nc[CH], rc[CH];

  // Reference state: recent input samples per channel (index 0 = newest),
  // accepted level and length of the current active-hold run.
  bit            hist[CH][HL];
  logic [CH-1:0] m_lvl;
  int            acnt[CH];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_lvl = '0;
    for (int c = 0; c < CH; c++) begin
      acnt[c] = 0;
      for (int j = 0; j < HL; j++) hist[c][j] = 1'b0;
    end
  endtask

  // A new level is accepted once the synchronised input has differed from the
  // current level for DB consecutive edges; repeat pulses fall on hold-run
  // lengths RS, RS+RP, RS+2RP, ...
  task automatic model_step(output exp_t e);
    e = '0;
    if (rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < CH; c++) begin
      logic L;
      bit   acc;
      L   = m_lvl[c];
      acc = 1'b1;
      for (int j = 0; j < DB; j++)
        if (hist[c][SS-1+j] == L) acc = 1'b0;
      if (L && repeat_en[c]) acnt[c]++;
      else                   acnt[c] = 0;
      if (acnt[c] >= RS && ((acnt[c] - RS) % RP) == 0) e.r[c] = 1'b1;
      if (acc) begin
        m_lvl[c] = ~L;
        if (L) e.n[c] = 1'b1;
        else   e.p[c] = 1'b1;
      end
      for (int j = HL - 1; j > 0; j--) hist[c][j] = hist[c][j-1];
      hist[c][0] = level_in[c];
    end
    e.lvl = m_lvl;
    e.any = |(e.p | e.n);
  endtask

  task automatic tick(input logic [CH-1:0] li, input logic [CH-1:0] re);
    exp_t e;
    level_in  = li;
    repeat_en = re;
    model_step(e);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    for (int c = 0; c < CH; c++) begin
      pc[c] = 0; nc[c] = 0; rc[c] = 0;
    end
    forever begin
      @(posedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("level_out", int'(level_out), int'(e.lvl));
        chk("p_edge",    int'(p_edge),    int'(e.p));
        chk("n_edge",    int'(n_edge),    int'(e.n));
        chk("rpt_pulse", int'(rpt_pulse), int'(e.r));
        chk("any_edge",  int'(any_edge),  int'(e.any));
        for (int c = 0; c < CH; c++) begin
          pc[c] += int'(p_edge[c]);
          nc[c] += int'(n_edge[c]);
          rc[c] += int'(rpt_pulse[c]);
        end
      end
    end
  end

  initial begin : stim
    logic [CH-1:0] li, re;
    int s0, s1;
    model_reset();
    li = 4'b0001;
    re = '0;
    repeat (3) tick(li, re);
    rst = 1'b0;

    // level_in[0] held through reset, then clean release / press / release
    repeat (10) tick(li, re);
    li[0] = 1'b0; repeat (10) tick(li, re);
    li[0] = 1'b1; repeat (10) tick(li, re);
    li[0] = 1'b0; repeat (10) tick(li, re);

    // bounce on channel 1
    s0 = pc[1]; s1 = nc[1];
    li[1] = 1'b1; tick(li, re);
    li[1] = 1'b0; repeat (2) tick(li, re);
    li[1] = 1'b1; repeat (3) tick(li, re);
    li[1] = 1'b0; tick(li, re);
    li[1] = 1'b1; repeat (12) tick(li, re);
    #5;
    chk("bounce_p_count", pc[1] - s0, 1);
    chk("bounce_n_count", nc[1] - s1, 0);

    // auto-repeat on channel 2
    re[2] = 1'b1;
    s0 = rc[2];
    li[2] = 1'b1; repeat (30) tick(li, re);
    li[2] = 1'b0; repeat (15) tick(li, re);
    #5;
    chk("repeat_count", rc[2] - s0, 6);

    // repeat gating on channel 3, enable raised 10 cycles into the hold
    li[3] = 1'b1; repeat (16) tick(li, re);
    re[3] = 1'b1;
    s0 = rc[3];
    repeat (12) tick(li, re);
    #5;
    chk("late_enable_count", rc[3] - s0, 2);

    // reset while channel 0 debounce count is part-way
    re = '0;
    li[0] = 1'b1; repeat (4) tick(li, re);
    rst = 1'b1;
    model_reset();
    if (q.size() > 0) q[$] = '0;
    repeat (2) tick(li, re);
    rst = 1'b0;
    repeat (10) tick(li, re);

    // simultaneous presses on channels 0 and 3
    li = '0; repeat (10) tick(li, re);
    li = 4'b1001; repeat (10) tick(li, re);

    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 7) == 0)  li[c] = ~li[c];
        if ($urandom_range(0, 31) == 0) re[c] = ~re[c];
      end
      tick(li, re);
    end
    repeat (2) tick(li, re);
    #10;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_edge_debouncer.md
Name: multi_edge_debouncer

Overview:
- N-channel input conditioner for front-panel buttons and door switches.
- Per channel: synchroniser, then counter-based debouncer, then registered rising/falling-edge pulses, plus an optional hold-to-repeat pulse train (e.g. held "+time" key).
- Sits between raw pins and the control FSM; replaces the single-channel, undebounced edge detector.

Parameters:
- CHANNELS, 4, number of independent input channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new level (>=1).
- REPEAT_START, 50000000, cycles from p_edge to first rpt_pulse (>=1).
- REPEAT_PERIOD, 10000000, cycles between subsequent rpt_pulse (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- level_in  input  CHANNELS  raw asynchronous levels, bit i = channel i.
- repeat_en  input  CHANNELS  per-channel auto-repeat enable (synchronous to clk).
- level_out  output  CHANNELS  debounced level.
- p_edge  output  CHANNELS  one-cycle pulse, debounced 0->1.
- n_edge  output  CHANNELS  one-cycle pulse, debounced 1->0.
- rpt_pulse  output  CHANNELS  one-cycle auto-repeat pulse.
- any_edge  output  1  OR of all p_edge and n_edge bits (combinational from registered pulses).

Behaviour:
- Reset (async, rst=1):
  - All sync flops, level_out, debounce counters, repeat counters, repeat phase, p_edge, n_edge and rpt_pulse go to 0; any_edge=0.
  - No pulses are generated by reset assertion or deassertion.
- Channels are fully independent; no shared state apart from any_edge.
- Synchroniser: SYNC_STAGES-deep shift chain; its last stage is "sync".
- Debounce, per channel, with counter dcnt of width clog2(DEBOUNCE_CYCLES), minimum 1 bit:
  - sync == level_out: dcnt <= 0.
  - sync != level_out and dcnt == DEBOUNCE_CYCLES-1: level_out <= sync, dcnt <= 0.
  - Otherwise dcnt <= dcnt+1.
  - Any return of sync to level_out before acceptance restarts the count. A glitch shorter than DEBOUNCE_CYCLES cycles is never seen on level_out.
- Latency: count the first rising edge that samples the new level_in value as edge 1. level_out changes at edge SYNC_STAGES+DEBOUNCE_CYCLES (defaults-with-DEBOUNCE_CYCLES=1: edge 3).
- Edges:
  - p_edge/n_edge are registered and set on the same edge that level_out changes, so they are high exactly in the first cycle of the new level_out value.
  - Each pulse lasts exactly 1 cycle.
  - p_edge and n_edge are never both high on one channel.
- Post-reset: level_in held high through reset gives p_edge after normal latency (level_out resets to 0).
- Auto-repeat, per channel; states IDLE, WAIT, RPT; counter rcnt sized for max(REPEAT_START, REPEAT_PERIOD).
  - Active condition: level_out==1 and repeat_en==1. When it is false: state <= IDLE, rcnt <= 0, no rpt_pulse.
  - IDLE: when active, enter WAIT with rcnt <= 1.
  - WAIT: rcnt == REPEAT_START-1 -> rpt_pulse=1 next cycle, rcnt <= 0, go RPT; else rcnt+1.
  - RPT: rcnt == REPEAT_PERIOD-1 -> rpt_pulse=1 next cycle, rcnt <= 0; else rcnt+1.
  - Net effect: with repeat_en already high, the first rpt_pulse occurs exactly REPEAT_START cycles after the p_edge cycle, then every REPEAT_PERIOD cycles.
  - REPEAT_START=1 is legal: the first rpt_pulse is in the cycle after p_edge, never the same cycle.
  - repeat_en rising mid-hold: the count starts from that cycle as if p_edge had occurred there.
  - Release (n_edge) in the same cycle a pulse is due: no rpt_pulse.
- Reset mid-operation: immediate clear; partial debounce or repeat counts are discarded.

Test Plan:
- Bench override for all scenarios: CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_START=8, REPEAT_PERIOD=4.
- Clean press: level_in[0] 0->1 held -> level_out[0] rises at edge 6, p_edge[0] high for exactly that cycle; release -> n_edge[0] 6 edges later; any_edge mirrors both pulses.
- Bounce: level_in[1] toggles 1,0,1,0 with 1-3 cycle widths, then holds 1 -> exactly one p_edge[1], 6 edges after the final transition; no n_edge.
- Repeat: repeat_en[2]=1, hold level_in[2] for 30 cycles after p_edge -> rpt_pulse[2] at p_edge+8, +12, +16, +20, +24, +28; none after release.
- Repeat gating: repeat_en[3]=0 during hold -> no rpt_pulse. Raise repeat_en[3] 10 cycles into the hold -> first rpt_pulse 8 cycles later.
- Reset mid-count: assert rst when dcnt=2 on channel 0 -> all outputs 0 immediately. After release with level_in[0]=1 held -> p_edge[0] at edge 6 counted from the first post-reset edge.
- Independence: simultaneous presses on channels 0 and 3 -> both p_edge bits in the same cycle; any_edge=1 for one cycle.
